// File: rtl/e203_dtcm_arb_ctrl.sv
// rtl/e203_dtcm_arb_ctrl.sv - DTCM arbiter/sequencer: LSU vs EXT, 1-deep response, light sleep
// Optional round-robin arbitration via `E203_DTCM_ARB_RR_EN (default: fixed LSU priority).
module e203_dtcm_arb_ctrl #(
    parameter int AW      = 14,
    parameter int DW      = 32,
    parameter int MW      = 4,
    parameter int LS_IDLE = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lsu_cmd_valid,
    output logic          lsu_cmd_ready,
    input  logic          lsu_cmd_read,
    input  logic [AW-1:0] lsu_cmd_addr,
    input  logic [DW-1:0] lsu_cmd_wdata,
    input  logic [MW-1:0] lsu_cmd_wmask,
    output logic          lsu_rsp_valid,
    input  logic          lsu_rsp_ready,
    output logic [DW-1:0] lsu_rsp_rdata,
    input  logic          ext_cmd_valid,
    output logic          ext_cmd_ready,
    input  logic          ext_cmd_read,
    input  logic [AW-1:0] ext_cmd_addr,
    input  logic [DW-1:0] ext_cmd_wdata,
    input  logic [MW-1:0] ext_cmd_wmask,
    output logic          ext_rsp_valid,
    input  logic          ext_rsp_ready,
    output logic [DW-1:0] ext_rsp_rdata,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_ls,
    output logic          ram_ds,
    output logic          ram_sd
);

    localparam logic [7:0] LS_IDLE_C = 8'(LS_IDLE);

    typedef enum logic {ACTIVE = 1'b0, SLEEP = 1'b1} ls_state_t;

    ls_state_t     state_q;
    ls_state_t     state_d;
    logic [7:0]    idle_cnt_q;

    logic          rsp_valid_q;
    logic          rsp_owner_q;
    logic          rsp_read_q;
    logic          rsp_hold_q;
    logic [DW-1:0] hold_data_q;

    logic          gnt_ext;
    logic          rsp_fire;
    logic          can_accept;
    logic          accept;
    logic          sel_read;
    logic [DW-1:0] rsp_data;

`ifdef E203_DTCM_ARB_RR_EN
    logic last_ext_q;

    always_comb begin
        gnt_ext = ext_cmd_valid;
        if (lsu_cmd_valid && ext_cmd_valid) begin
            gnt_ext = ~last_ext_q;
        end
    end

    // Pointer starts at EXT so the first tie goes to the LSU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ext_q <= 1'b1;
        end else if (accept) begin
            last_ext_q <= gnt_ext;
        end
    end
`else
    always_comb begin
        gnt_ext = ~lsu_cmd_valid;
    end
`endif

    assign rsp_fire   = rsp_valid_q & (rsp_owner_q ? ext_rsp_ready : lsu_rsp_ready);
    assign can_accept = ~rst & ~ram_ls & (~rsp_valid_q | rsp_fire);

    assign lsu_cmd_ready = can_accept & lsu_cmd_valid & ~gnt_ext;
    assign ext_cmd_ready = can_accept & ext_cmd_valid & gnt_ext;
    assign accept        = lsu_cmd_ready | ext_cmd_ready;

    assign sel_read = gnt_ext ? ext_cmd_read : lsu_cmd_read;
    assign ram_cs   = accept;
    assign ram_we   = accept & ~sel_read;
    assign ram_addr = gnt_ext ? ext_cmd_addr : lsu_cmd_addr;
    assign ram_din  = gnt_ext ? ext_cmd_wdata : lsu_cmd_wdata;
    assign ram_wem  = sel_read ? '0 : (gnt_ext ? ext_cmd_wmask : lsu_cmd_wmask);
    assign ram_ds   = 1'b0;
    assign ram_sd   = 1'b0;

    // ram_dout is only valid for one cycle; a stalled read keeps its own copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_read_q  <= 1'b0;
            rsp_hold_q  <= 1'b0;
            hold_data_q <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_owner_q <= gnt_ext;
            rsp_read_q  <= sel_read;
            rsp_hold_q  <= 1'b0;
        end else if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
        end else if (rsp_valid_q && !rsp_hold_q) begin
            rsp_hold_q  <= 1'b1;
            hold_data_q <= ram_dout;
        end
    end

    assign rsp_data      = rsp_read_q ? (rsp_hold_q ? hold_data_q : ram_dout) : '0;
    assign lsu_rsp_valid = rsp_valid_q & ~rsp_owner_q;
    assign ext_rsp_valid = rsp_valid_q & rsp_owner_q;
    assign lsu_rsp_rdata = lsu_rsp_valid ? rsp_data : '0;
    assign ext_rsp_rdata = ext_rsp_valid ? rsp_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACTIVE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACTIVE: if (!ram_cs && idle_cnt_q >= LS_IDLE_C) state_d = SLEEP;
            SLEEP:  if (lsu_cmd_valid || ext_cmd_valid) state_d = ACTIVE;
            default: state_d = ACTIVE;
        endcase
    end

    always_comb begin
        ram_ls = (state_q == SLEEP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else if (state_q == SLEEP || ram_cs) begin
            idle_cnt_q <= '0;
        end else if (idle_cnt_q != 8'hFF) begin
            idle_cnt_q <= idle_cnt_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_e203_dtcm_arb_ctrl.sv
// tb/tb_e203_dtcm_arb_ctrl.sv - scoreboard bench for e203_dtcm_arb_ctrl with RAM and reference models
module tb_e203_dtcm_arb_ctrl;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int LS_IDLE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read;
    logic [AW-1:0] lsu_cmd_addr;
    logic [DW-1:0] lsu_cmd_wdata;
    logic [MW-1:0] lsu_cmd_wmask;
    logic          lsu_rsp_valid, lsu_rsp_ready;
    logic [DW-1:0] lsu_rsp_rdata;
    logic          ext_cmd_valid, ext_cmd_ready, ext_cmd_read;
    logic [AW-1:0] ext_cmd_addr;
    logic [DW-1:0] ext_cmd_wdata;
    logic [MW-1:0] ext_cmd_wmask;
    logic          ext_rsp_valid, ext_rsp_ready;
    logic [DW-1:0] ext_rsp_rdata;
    logic          ram_cs, ram_we, ram_ls, ram_ds, ram_sd;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    e203_dtcm_arb_ctrl #(.AW(AW), .DW(DW), .MW(MW), .LS_IDLE(LS_IDLE)) dut (
        .clk(clk), .rst(rst),
        .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready), .lsu_cmd_read(lsu_cmd_read),
        .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
        .ext_cmd_valid(ext_cmd_valid), .ext_cmd_ready(ext_cmd_ready), .ext_cmd_read(ext_cmd_read),
        .ext_cmd_addr(ext_cmd_addr), .ext_cmd_wdata(ext_cmd_wdata), .ext_cmd_wmask(ext_cmd_wmask),
        .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready), .ext_rsp_rdata(ext_rsp_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_ls(ram_ls), .ram_ds(ram_ds), .ram_sd(ram_sd)
    );

    // Behavioural single-port RAM; dout is scrambled on idle cycles so stale data is visible.
    bit [31:0]   ram_mem [int];
    logic [31:0] ram_word;
    always @(posedge clk) begin
        if (ram_cs) begin
            ram_word = ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : 32'h0;
            ram_dout <= ram_word;
            if (ram_we) begin
                for (int b = 0; b < MW; b++) if (ram_wem[b]) ram_word[8*b +: 8] = ram_din[8*b +: 8];
                ram_mem[int'(ram_addr)] = ram_word;
            end
        end else begin
            ram_dout <= $urandom;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model and scoreboard
    bit [31:0]   ref_mem [int];
    logic [31:0] lsu_q [$];
    logic [31:0] ext_q [$];
    bit          last_ext = 1'b1;
    bit          prev_acc = 1'b0;
    bit          prev_who = 1'b0;
    bit          lsu_acc = 1'b0;
    bit          ext_acc = 1'b0;
    logic [31:0] last_lsu_rdata = 32'h0;
    logic [31:0] last_ext_rdata = 32'h0;

    task automatic pop_check(input bit who, input logic [31:0] rdata);
        logic [31:0] e;
        if (who ? ext_q.size() == 0 : lsu_q.size() == 0) begin
            chk(who ? "ext_rsp_unexpected" : "lsu_rsp_unexpected", 1, 0);
        end else begin
            e = who ? ext_q.pop_front() : lsu_q.pop_front();
            chk(who ? "ext_rdata" : "lsu_rdata", rdata, e);
        end
        if (who) last_ext_rdata = rdata;
        else last_lsu_rdata = rdata;
    endtask

    always @(negedge clk) begin
        bit who, exp_who, rd, acc, exp_acc;
        logic [13:0] a;
        logic [31:0] d, cur;
        logic [3:0] m;
        if (rst) begin
            lsu_q.delete();
            ext_q.delete();
            last_ext = 1'b1;
            prev_acc = 1'b0;
            lsu_acc = 1'b0;
            ext_acc = 1'b0;
        end else begin
            if (lsu_rsp_valid && lsu_rsp_ready) pop_check(1'b0, lsu_rsp_rdata);
            if (ext_rsp_valid && ext_rsp_ready) pop_check(1'b1, ext_rsp_rdata);
            if (prev_acc) chk("rsp_latency", prev_who ? ext_rsp_valid : lsu_rsp_valid, 1);
            if (ram_ls) chk("ready_in_sleep", {lsu_cmd_ready, ext_cmd_ready}, 0);
            lsu_acc = lsu_cmd_valid && lsu_cmd_ready;
            ext_acc = ext_cmd_valid && ext_cmd_ready;
            acc = lsu_acc || ext_acc;
            exp_acc = !ram_ls && (lsu_q.size() + ext_q.size() == 0) && (lsu_cmd_valid || ext_cmd_valid);
            chk("accept", acc, exp_acc);
            chk("ram_cs", ram_cs, acc);
            if (lsu_acc && ext_acc) chk("dual_accept", 1, 0);
            prev_acc = acc;
            if (acc) begin
                who = ext_acc;
`ifdef E203_DTCM_ARB_RR_EN
                exp_who = (lsu_cmd_valid && ext_cmd_valid) ? !last_ext : ext_cmd_valid;
`else
                exp_who = !lsu_cmd_valid;
`endif
                chk("grant", who, exp_who);
                rd = who ? ext_cmd_read : lsu_cmd_read;
                a  = who ? ext_cmd_addr : lsu_cmd_addr;
                d  = who ? ext_cmd_wdata : lsu_cmd_wdata;
                m  = who ? ext_cmd_wmask : lsu_cmd_wmask;
                chk("ram_addr", ram_addr, a);
                chk("ram_we", ram_we, !rd);
                chk("ram_wem", ram_wem, rd ? 4'h0 : m);
                if (!rd) chk("ram_din", ram_din, d);
                cur = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
                if (rd) begin
                    if (who) ext_q.push_back(cur);
                    else lsu_q.push_back(cur);
                end else begin
                    for (int b = 0; b < 4; b++) if (m[b]) cur[8*b +: 8] = d[8*b +: 8];
                    ref_mem[int'(a)] = cur;
                    if (who) ext_q.push_back(32'h0);
                    else lsu_q.push_back(32'h0);
                end
                last_ext = who;
                prev_who = who;
            end
        end
    end

    task automatic set_cmd(input bit who, input bit rd, input logic [13:0] a, input logic [31:0] d,
                           input logic [3:0] m);
        if (who) begin
            ext_cmd_read = rd; ext_cmd_addr = a; ext_cmd_wdata = d; ext_cmd_wmask = m; ext_cmd_valid = 1'b1;
        end else begin
            lsu_cmd_read = rd; lsu_cmd_addr = a; lsu_cmd_wdata = d; lsu_cmd_wmask = m; lsu_cmd_valid = 1'b1;
        end
    endtask

    task automatic rand_cmd(input bit who);
        set_cmd(who, 1'($urandom % 2), 14'h40 + 14'($urandom % 16), $urandom, 4'($urandom));
    endtask

    task automatic issue(input bit who, input bit rd, input logic [13:0] a, input logic [31:0] d,
                         input logic [3:0] m, output int waited);
        bit got = 1'b0;
        waited = 0;
        set_cmd(who, rd, a, d, m);
        while (!got && waited < 40) begin
            @(negedge clk);
            waited++;
            got = who ? ext_cmd_ready : lsu_cmd_ready;
        end
        if (!got) chk("issue_timeout", 0, 1);
        @(posedge clk); #1;
        if (who) ext_cmd_valid = 1'b0;
        else lsu_cmd_valid = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk); @(posedge clk); #1;
    endtask

    initial begin
        int w, idle_left;
        bit got, who;
        rst = 1'b1;
        set_cmd(1'b0, 1'b1, 14'h0, 32'h0, 4'h0);
        set_cmd(1'b1, 1'b1, 14'h0, 32'h0, 4'h0);
        lsu_rsp_ready = 1'b1;
        ext_rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst_ram_cs", ram_cs, 0);
        chk("rst_ram_ls", ram_ls, 0);
        chk("rst_cmd_ready", {lsu_cmd_ready, ext_cmd_ready}, 0);
        chk("rst_rsp_valid", {lsu_rsp_valid, ext_rsp_valid}, 0);
        chk("rst_rdata", lsu_rsp_rdata | ext_rsp_rdata, 0);
        @(posedge clk); #1;
        lsu_cmd_valid = 1'b0;
        ext_cmd_valid = 1'b0;
        rst = 1'b0;
        settle();

        // Read after write, back-to-back
        issue(1'b0, 1'b0, 14'h10, 32'hDEADBEEF, 4'hF, w);
        issue(1'b0, 1'b1, 14'h10, 32'h0, 4'h0, w);
        chk("raw_back_to_back", w, 1);
        settle();
        chk("raw_rdata", last_lsu_rdata, 32'hDEADBEEF);

        // Byte mask
        issue(1'b0, 1'b0, 14'h20, 32'hFFFFFFFF, 4'hF, w);
        issue(1'b0, 1'b0, 14'h20, 32'h11223344, 4'h5, w);
        issue(1'b0, 1'b1, 14'h20, 32'h0, 4'h0, w);
        settle();
        chk("mask_rdata", last_lsu_rdata, 32'hFF22FF44);

        // Response backpressure with a pending EXT command
        lsu_rsp_ready = 1'b0;
        issue(1'b0, 1'b1, 14'h10, 32'h0, 4'h0, w);
        set_cmd(1'b1, 1'b1, 14'h20, 32'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_rsp_valid", lsu_rsp_valid, 1);
            chk("bp_rdata", lsu_rsp_rdata, 32'hDEADBEEF);
            chk("bp_cmd_ready", {lsu_cmd_ready, ext_cmd_ready}, 0);
        end
        @(posedge clk); #1;
        lsu_rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_accept", ext_cmd_ready, 1);
        @(posedge clk); #1;
        ext_cmd_valid = 1'b0;

        // Contention: both requesters valid continuously
        rand_cmd(1'b0);
        rand_cmd(1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("contention_accept", lsu_cmd_ready | ext_cmd_ready, 1);
            who = ext_cmd_ready;
`ifdef E203_DTCM_ARB_RR_EN
            chk("contention_order", who, (k % 2) == 1);
`else
            chk("contention_order", who, 0);
`endif
            @(posedge clk); #1;
            rand_cmd(who);
        end
        lsu_cmd_valid = 1'b0;
        @(negedge clk);
        chk("ext_after_lsu_drop", ext_cmd_ready, 1);
        @(posedge clk); #1;
        ext_cmd_valid = 1'b0;

        // Sleep and wake
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ls_early", ram_ls, 0);
        end
        got = 1'b0;
        for (int k = 0; k < 2 && !got; k++) begin
            @(negedge clk);
            got = ram_ls;
        end
        chk("ls_rise", got, 1);
        @(posedge clk); #1;
        set_cmd(1'b1, 1'b1, 14'h10, 32'h0, 4'h0);
        @(negedge clk);
        chk("wake_ls_held", ram_ls, 1);
        chk("wake_no_ready", ext_cmd_ready, 0);
        @(negedge clk);
        chk("wake_ls_low", ram_ls, 0);
        chk("wake_accept", ext_cmd_ready, 1);
        @(posedge clk); #1;
        ext_cmd_valid = 1'b0;
        settle();
        chk("wake_rdata", last_ext_rdata, 32'hDEADBEEF);

        // Reset while a response is stalled
        lsu_rsp_ready = 1'b0;
        issue(1'b0, 1'b1, 14'h10, 32'h0, 4'h0, w);
        @(negedge clk);
        chk("pre_rst_rsp_valid", lsu_rsp_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_rsp_valid", lsu_rsp_valid, 0);
        chk("rst_mid_ram_cs", ram_cs, 0);
        chk("rst_mid_ram_ls", ram_ls, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        lsu_rsp_ready = 1'b1;
        last_lsu_rdata = 32'h0;
        issue(1'b0, 1'b1, 14'h10, 32'h0, 4'h0, w);
        settle();
        chk("post_rst_rdata", last_lsu_rdata, 32'hDEADBEEF);

        // Randomized traffic with idle bursts
        idle_left = 0;
        for (int c = 0; c < 1500; c++) begin
            if (idle_left > 0) begin
                idle_left--;
                if (!lsu_cmd_valid || lsu_acc) lsu_cmd_valid = 1'b0;
                if (!ext_cmd_valid || ext_acc) ext_cmd_valid = 1'b0;
            end else begin
                if ($urandom % 80 == 0) idle_left = 4 + int'($urandom % 8);
                if (!lsu_cmd_valid || lsu_acc) begin
                    rand_cmd(1'b0);
                    lsu_cmd_valid = ($urandom % 3) != 0;
                end
                if (!ext_cmd_valid || ext_acc) begin
                    rand_cmd(1'b1);
                    ext_cmd_valid = ($urandom % 3) != 0;
                end
            end
            lsu_rsp_ready = ($urandom % 4) != 0;
            ext_rsp_ready = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end
        while (lsu_cmd_valid || ext_cmd_valid) begin
            if (lsu_acc) lsu_cmd_valid = 1'b0;
            if (ext_acc) ext_cmd_valid = 1'b0;
            lsu_rsp_ready = 1'b1;
            ext_rsp_ready = 1'b1;
            @(posedge clk); #1;
        end
        lsu_rsp_ready = 1'b1;
        ext_rsp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("drain_empty", lsu_q.size() + ext_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
